// File: rtl/stack_pkg.sv
// Shared types and helpers for the 65C02 stack sequencer.
package stack_pkg;

  // Stack operation offered by instruction decode. Bit 2 marks a pull.
  typedef enum logic [2:0] {
    PUSH1 = 3'd0,
    PUSH2 = 3'd1,
    PUSH3 = 3'd2,
    PULL1 = 3'd4,
    PULL2 = 3'd5,
    PULL3 = 3'd6
  } stack_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE_INC = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    FINISH  = 3'd4
  } stk_state_t;

  // The 6502 family hardwires the stack to page 1.
  localparam logic [7:0] STACK_PAGE = 8'h01;

  // Byte count of an operation; unused encodings behave as single-byte ops.
  function automatic logic [1:0] op_len(input stack_op_t op);
    case (op)
      PUSH2, PULL2: op_len = 2'd2;
      PUSH3, PULL3: op_len = 2'd3;
      default:      op_len = 2'd1;
    endcase
  endfunction

  function automatic logic op_is_pull(input stack_op_t op);
    op_is_pull = op[2];
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Multi-byte stack push/pull sequencer for the 65C02 core.
// Optional feature: define STACK_WRAP_DETECT_EN to build the sticky
// stack_wrap detector; otherwise stack_wrap is tied low.
//
// Handshake: an operation is accepted on a rising edge where
// req_valid && req_ready. req_ready is high only in IDLE, so at most one
// operation is in flight; req_op and push_data are sampled on that edge only.
module stack_sequencer
  import stack_pkg::*;
(
  input  logic        fclk,
  input  logic        resb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [23:0] push_data,
  input  logic [7:0]  sp_in,
  output logic        sp_increment,
  output logic        sp_decrement,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rdy,
  output logic [23:0] pull_data,
  output logic        done,
  output logic        busy,
  output logic        stack_wrap
);

  stk_state_t  state_q;
  logic [1:0]  rem_q;    // bytes still to transfer
  logic [1:0]  idx_q;    // pull byte slot being filled
  logic [23:0] wdata_q;  // push bytes; the current byte sits in [7:0]
  logic [23:0] pull_q;
  stack_op_t   req_op_e;
  logic        last_byte;
  logic        access;

  assign req_op_e  = stack_op_t'(req_op);
  assign last_byte = (rem_q == 2'd1);
  assign access    = (state_q == WRITE) || (state_q == READ);

  // Sequencer FSM with byte counter, push shifter and pull capture.
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
      idx_q   <= 2'd0;
      wdata_q <= 24'h0;
      pull_q  <= 24'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rem_q <= op_len(req_op_e);
            idx_q <= 2'd0;
            if (op_is_pull(req_op_e)) begin
              pull_q  <= 24'h0;
              state_q <= PRE_INC;
            end else begin
              wdata_q <= push_data;
              state_q <= WRITE;
            end
          end
        end
        PRE_INC: state_q <= READ;
        WRITE: begin
          if (mem_rdy) begin
            wdata_q <= {8'h00, wdata_q[23:8]};
            rem_q   <= rem_q - 2'd1;
            if (last_byte) state_q <= FINISH;
          end
        end
        READ: begin
          if (mem_rdy) begin
            case (idx_q)
              2'd0:    pull_q[7:0]   <= mem_rdata;
              2'd1:    pull_q[15:8]  <= mem_rdata;
              default: pull_q[23:16] <= mem_rdata;
            endcase
            idx_q <= idx_q + 2'd1;
            rem_q <= rem_q - 2'd1;
            if (last_byte) state_q <= FINISH;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state; mem_rdy only gates the SP strobes so a
  // stalled access never moves SP.
  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign mem_we       = (state_q == WRITE);
  assign mem_re       = (state_q == READ);
  assign mem_addr     = access ? {STACK_PAGE, sp_in} : 16'h0000;
  assign mem_wdata    = mem_we ? wdata_q[7:0] : 8'h00;
  assign sp_decrement = mem_we && mem_rdy;
  assign sp_increment = (state_q == PRE_INC) || (mem_re && mem_rdy && !last_byte);
  assign pull_data    = pull_q;

`ifdef STACK_WRAP_DETECT_EN
  logic wrap_q;

  // Sticky flag: a write at SP=00 or an increment from SP=FF wraps the page.
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      wrap_q <= 1'b0;
    end else if ((mem_we && (sp_in == 8'h00)) || (sp_increment && (sp_in == 8'hFF))) begin
      wrap_q <= 1'b1;
    end
  end

  assign stack_wrap = wrap_q;
`else
  assign stack_wrap = 1'b0;
`endif

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Drives multi-byte stack pushes and pulls for the 65C02 core. It sits directly upstream of the stack pointer register: it accepts a stack operation from instruction decode, issues one page-1 memory access per byte, and strobes the SP increment/decrement lines. It honours the RDY wait-state input and returns pulled bytes with a completion pulse.

## Interface
Parameters:
- None. Widths are fixed by the 65C02 architecture.

Ports:
- fclk  in  1  core clock; all state changes on the rising edge.
- resb  in  1  asynchronous, active-low reset.
- req_valid  in  1  a stack operation is offered.
- req_ready  out  1  high only in IDLE. An operation is accepted on an edge where req_valid && req_ready.
- req_op  in  3  stack_op_t: PUSH1, PUSH2, PUSH3, PULL1, PULL2, PULL3.
- push_data  in  24  push bytes, sampled at accept. Byte0 (bits 7:0) is written first.
- sp_in  in  8  current SP value from the stack pointer register.
- sp_increment  out  1  one-cycle SP +1 strobe.
- sp_decrement  out  1  one-cycle SP −1 strobe.
- mem_addr  out  16  {8'h01, sp_in} during access cycles, else 16'h0000.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte.
- mem_rdy  in  1  RDY; low stalls the current access.
- pull_data  out  24  pulled bytes; byte0 = first pulled. Valid while done is high.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever the state is not IDLE.
- stack_wrap  out  1  sticky SP wrap flag. See Configuration.

## Operation
- States: IDLE, PRE_INC, WRITE, READ, FINISH. A 2-bit byte counter `rem` holds the bytes still to transfer.
- IDLE: on accept, latch the op, push_data and count n = 1..3.
  - A push goes to WRITE.
  - A pull goes to PRE_INC.
- PRE_INC: assert sp_increment for one cycle, then go to READ. This is independent of mem_rdy: it is an internal cycle with no bus access.
- WRITE:
  - Drive mem_we = 1 and mem_wdata = the current byte, at address {01, sp_in}.
  - When mem_rdy = 1: assert sp_decrement and advance the byte.
  - After the last byte, go to FINISH.
- READ:
  - Drive mem_re = 1 at {01, sp_in}.
  - When mem_rdy = 1: capture mem_rdata into pull_data byte k.
  - If more bytes remain, assert sp_increment in the same cycle. The next read then sees SP+1 (pre-increment semantics).
  - After the last byte, go to FINISH. The final byte does not increment.
- FINISH: done = 1 for one cycle, then go to IDLE.
- Stall: while mem_rdy = 0 in WRITE or READ:
  - state, counter, address, we/re and wdata are all held;
  - sp_increment and sp_decrement are forced to 0.
- Strobes are mutually exclusive; sp_increment and sp_decrement are never high together.
- Byte order matches the 65C02 conventions:
  - BRK/IRQ/NMI: PUSH3 with byte0 = PCH, byte1 = PCL, byte2 = P.
  - RTI: PULL3 returns byte0 = P, byte1 = PCL, byte2 = PCH.
  - JSR: PUSH2 with byte0 = PCH.
  - RTS: PULL2 with byte0 = PCL.
- Address arithmetic is 8-bit. SP wraps inside the SP register, so the address always stays within 0x0100–0x01FF.
- pull_data holds its value until the next pull is accepted. Push operations leave it unchanged.

## Timing
- Reset (resb low, any state):
  - state = IDLE and rem = 0;
  - all strobes, mem_we, mem_re, done, busy and stack_wrap = 0;
  - mem_addr, mem_wdata and pull_data = 0;
  - req_ready = 1.
- Reset mid-operation abandons the sequence with no further strobes.
- Accept edge is cycle 0.
  - PUSHn with no stalls: WRITE in cycles 1..n, done in cycle n+1.
  - PULLn with no stalls: PRE_INC in cycle 1, READ in cycles 2..n+1, done in cycle n+2.
- Each stall cycle adds exactly one cycle of latency.
- req_ready is low from cycle 1 through FINISH. A new request is accepted no earlier than the cycle after done.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_valid to the memory outputs.

## Configuration
- STACK_WRAP_DETECT_EN defined:
  - stack_wrap sets on a write issued while sp_in = 8'h00;
  - it also sets on any sp_increment issued while sp_in = 8'hFF;
  - it clears only on reset.
- Macro undefined: stack_wrap is tied to 0 and no detection logic is built.
- The port list is identical either way.

## Structure
- Package stack_pkg holds:
  - stack_op_t (3-bit enum);
  - stk_state_t;
  - STACK_PAGE = 8'h01;
  - helper function op_len(stack_op_t) returning 1..3;
  - function op_is_pull().
- No sub-module: a single FSM plus its counter and byte mux/capture registers.

## Test plan
- Reset: sp_in = 8'hFF, PUSH3 with push_data = 24'h30_34_12 → writes 12 at 01FF, 34 at 01FE, 30 at 01FD; three sp_decrement pulses; done in cycle 4.
- PULL2: sp_in tracked by a bench SP model starting at 8'hFD, memory 01FE = CD, 01FF = AB → sp_increment in cycles 1 and 2; pull_data[15:0] = 16'hABCD; done in cycle 4.
- Stall: PUSH1 with mem_rdy low for 3 cycles in WRITE → mem_we and mem_addr held, no sp_decrement until mem_rdy is high; done in cycle 5.
- Reset mid-PULL3, asserted in the second READ cycle → all outputs 0 immediately; no strobe afterwards; req_ready = 1 after release.
- With STACK_WRAP_DETECT_EN: PUSH2 starting at sp_in = 8'h00 → stack_wrap = 1 and stays set. Without the macro, the same stimulus gives stack_wrap = 0.
- Back-to-back: req_valid held high across PULL1 then PUSH1 → second accept occurs the cycle after done; strobes are never simultaneous.
